// File: rtl/e203_exu_flush_ctrl_pkg.sv
// Shared types for the EXU flush arbiter: FSM states, grant owner id and default widths.
package e203_exu_flush_ctrl_pkg;

  localparam int E203_PC_SIZE = 32;
  localparam int FLUSH_CNT_W  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } flush_state_e;

  typedef enum logic {
    WIN_EXCP = 1'b0,
    WIN_BRCH = 1'b1
  } flush_win_e;

endpackage

// File: rtl/e203_exu_flush_ctrl_satcnt.sv
// Saturating event counter: increments on inc, sticks at all-ones, clr wins over inc.
// Latency: count visible the cycle after the event. Backpressure: none.
module e203_exu_flush_satcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/e203_exu_flush_ctrl.sv
// Flush arbiter excp > brch toward the IFU; per-source counters under E203_FLUSH_PERF_CNT_EN.
// Latency: zero-cycle grant in IDLE; a refused flush is locked in HOLD until the IFU acks.
// Backpressure: requester acks only on pipe_flush_req & pipe_flush_ack; HOLD blocks preemption.
module e203_exu_flush_ctrl
  import e203_exu_flush_ctrl_pkg::*;
#(
  parameter int PC_SIZE = E203_PC_SIZE,
  parameter int CNT_W   = FLUSH_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               excp_flush_req,
  input  logic [PC_SIZE-1:0] excp_flush_add_op1,
  input  logic [PC_SIZE-1:0] excp_flush_add_op2,
  output logic               excp_flush_ack,
  input  logic               brch_flush_req,
  input  logic [PC_SIZE-1:0] brch_flush_add_op1,
  input  logic [PC_SIZE-1:0] brch_flush_add_op2,
  output logic               brch_flush_ack,
  output logic               pipe_flush_req,
  output logic [PC_SIZE-1:0] pipe_flush_add_op1,
  output logic [PC_SIZE-1:0] pipe_flush_add_op2,
  input  logic               pipe_flush_ack,
  output logic               flush_pulse,
  output logic               flush_busy,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   excp_flush_cnt,
  output logic [CNT_W-1:0]   brch_flush_cnt
);

  flush_state_e       state_q, state_d;
  flush_win_e         win_q, win_d, win_cur;
  logic [PC_SIZE-1:0] op1_q, op1_d, op2_q, op2_d;

  always_comb begin
    state_d            = state_q;
    win_d              = win_q;
    op1_d              = op1_q;
    op2_d              = op2_q;
    win_cur            = excp_flush_req ? WIN_EXCP : WIN_BRCH;
    pipe_flush_req     = excp_flush_req | brch_flush_req;
    pipe_flush_add_op1 = excp_flush_req ? excp_flush_add_op1 : brch_flush_add_op1;
    pipe_flush_add_op2 = excp_flush_req ? excp_flush_add_op2 : brch_flush_add_op2;
    if (state_q == ST_HOLD) begin
      // Grant is locked: live requester inputs are ignored until the IFU accepts.
      win_cur            = win_q;
      pipe_flush_req     = 1'b1;
      pipe_flush_add_op1 = op1_q;
      pipe_flush_add_op2 = op2_q;
      if (pipe_flush_ack) begin
        state_d = ST_IDLE;
      end
    end else if (pipe_flush_req && !pipe_flush_ack) begin
      state_d = ST_HOLD;
      win_d   = win_cur;
      op1_d   = pipe_flush_add_op1;
      op2_d   = pipe_flush_add_op2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= WIN_EXCP;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  assign flush_pulse    = pipe_flush_req & pipe_flush_ack;
  assign flush_busy     = (state_q == ST_HOLD);
  assign excp_flush_ack = flush_pulse & (win_cur == WIN_EXCP);
  assign brch_flush_ack = flush_pulse & (win_cur == WIN_BRCH);

`ifdef E203_FLUSH_PERF_CNT_EN
  e203_exu_flush_satcnt #(.W(CNT_W)) u_excp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (excp_flush_ack),
    .cnt   (excp_flush_cnt)
  );

  e203_exu_flush_satcnt #(.W(CNT_W)) u_brch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (brch_flush_ack),
    .cnt   (brch_flush_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign excp_flush_cnt = '0;
  assign brch_flush_cnt = '0;
`endif

endmodule
